decode_stage_hs: RTL
====================

Name: decode_stage_hs

Overview:
Parametrised successor of the in-order decode stage. It performs instruction field extraction, a 32-entry register file with write-through bypass, immediate generation, N-source operand forwarding, branch compare and jump-target computation. The ID/EX boundary is a valid/ready pipeline register with a skid entry and flush, in place of a bare load-enable register. It sits between the fetch stage and the execute stage of the RV32I core.

Parameters:
XLEN, 32, datapath width; 32 for RV32I.
NUM_FWD, 3, number of forwarding sources; must be 1..7.
CTRL_W, 12, width of the opaque control bundle carried to EX.
FS_W (localparam), $clog2(NUM_FWD+1), width of each forwarding-select field.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
id_valid_i  in  1  instruction and PC valid from IF.
id_ready_o  out  1  stage can accept an instruction.
inst_i  in  32  instruction word.
pc_i  in  XLEN  PC of inst_i.
ctrl_i  in  CTRL_W  control bundle from the controller.
nop_i  in  1  zero the control bundle (bubble insertion).
flush_i  in  1  discard all held and incoming work.
imm_typ_i  in  3  immediate format select.
jalr_i  in  1  jump base is rs1 (1) or PC (0).
alu_src1_i  in  1  0: rs1 operand; 1: PC.
alu_src2_i  in  2  0: rs2 operand; 1: imm; 2: constant 4; 3: zero.
sgn_unsgn_i  in  1  0: signed compare; 1: unsigned compare.
fwd_sel1_i, fwd_sel2_i  in  FS_W each  0: RF; k: fwd_data_i slice k-1.
fwd_data_i  in  NUM_FWD*XLEN  forwarding buses; slice k is bits [k*XLEN +: XLEN].
rf_we_i  in  1  register-file write enable (from WB).
rf_waddr_i  in  5  register-file write address.
rf_wdata_i  in  XLEN  register-file write data.
rs1_o, rs2_o, opcode_o, func3_o, func7_o  out  5,5,7,3,7  decoded fields for the hazard unit and controller.
eq_o, lt_o, ge_o  out  1 each  branch compare flags.
jump_addr_o  out  XLEN  jump/branch target.
ex_valid_o  out  1  ID/EX holds a valid entry.
ex_ready_i  in  1  EX accepts the entry.
ex_ctrl_o  out  CTRL_W  registered control bundle.
ex_pc_o  out  XLEN  registered PC.
ex_a_o  out  XLEN  registered ALU operand A.
ex_b_o  out  XLEN  registered ALU operand B.
ex_sdata_o  out  XLEN  registered forwarded rs2 value (store data).
ex_rd_o  out  5  registered destination register.

Behaviour:
- Reset (rst=0, asynchronous): all RF entries, the ID/EX payload and the skid payload clear to 0; ex_valid_o=0; skid valid=0; id_ready_o=1.
- Register file:
  - Write on the rising edge when rf_we_i=1 and rf_waddr_i!=0. x0 always reads 0.
  - Reads are combinational. If rf_we_i=1, rf_waddr_i==rs and rs!=0, the read returns rf_wdata_i (write-through bypass).
- Immediate (sign-extended to XLEN), by imm_typ_i:
  - 0: I-type. 1: S-type. 2: B-type with bit0=0. 3: U-type, {inst[31:12], 12'b0}. 4: J-type with bit0=0.
  - 5: shamt, zero-extended inst[24:20]. 6 and 7: zero.
- Operand forwarding:
  - opN = fwd_selN_i==0 ? RF read : fwd_data_i slice (fwd_selN_i-1).
  - A select value above NUM_FWD yields 0.
- ALU operands:
  - A = alu_src1_i ? pc_i : op1.
  - B per alu_src2_i (0: op2; 1: imm; 2: constant 4; 3: zero).
- Branch compare (combinational, on op1 and op2):
  - eq_o = (op1==op2).
  - lt_o is a signed or unsigned less-than per sgn_unsgn_i.
  - ge_o = ~lt_o.
- Jump target:
  - jump_addr_o = (jalr_i ? op1 : pc_i) + imm, modulo 2^XLEN.
  - Bit0 is forced to 0 when jalr_i=1.
- Handshakes:
  - Accept when id_valid_i & id_ready_o.
  - Captured payload = {nop_i ? 0 : ctrl_i, pc_i, A, B, op2, inst[11:7]}.
  - Entry leaves when ex_valid_o & ex_ready_i.
- ID/EX main register loads when it is empty or being drained:
  - From skid if skid valid; otherwise from an accepted input.
  - ex_valid_o updates accordingly.
- Skid entry:
  - Captures the accepted input when the main register is full and ex_ready_i=0.
  - id_ready_o = ~skid_valid, driven from a register (no combinational path from ex_ready_i).
- Order and throughput:
  - Entries are delivered strictly in acceptance order.
  - One transfer per cycle is sustained when ex_ready_i=1 continuously.
- ex_* outputs hold stable while ex_valid_o=1 and ex_ready_i=0.
- flush_i=1 (synchronous, highest priority):
  - Next edge: ex_valid_o=0 and skid_valid=0. Any same-cycle accept is discarded.
  - Payload registers may retain stale values.
- Simultaneous drain and accept with the skid empty: the main register takes the new entry and the skid stays empty.

Optional Feature:
DECODE_SKID_EN
- Defined: skid entry present; id_ready_o registered as above.
- Undefined: no skid; id_ready_o = ~ex_valid_o | ex_ready_i (combinational); main register loads on accept. All other behaviour is unchanged.

Test Plan:
- Reset release with no input -> id_ready_o=1, ex_valid_o=0, all ex_* outputs 0.
- Write x5=0x00000010 and x6=0xFFFFFFF0, then decode beq x5,x6 with sgn_unsgn_i=0 -> eq_o=0, lt_o=0, ge_o=1. Repeat with sgn_unsgn_i=1 -> lt_o=1.
- Decode inst reading x7 in the same cycle as rf_we_i=1, rf_waddr_i=7, rf_wdata_i=0xABCD -> op1=0xABCD. A read of x0 with a concurrent write to x0 returns 0.
- Fwd: fwd_sel1_i=2 with slice1=0x1234 and alu_src1_i=0 -> ex_a_o=0x1234 after accept. jalr_i=1 with imm=3 -> jump_addr_o=0x1236.
- Hold ex_ready_i=0 and present 3 back-to-back valid inputs -> first in main, second in skid, id_ready_o=0. Release ex_ready_i -> outputs appear in order with no loss or duplication.
- Fill main and skid, then assert flush_i=1 for one cycle together with id_valid_i=1 -> ex_valid_o=0 and id_ready_o=1 next cycle, and the flushed input never appears at EX.

Source files
------------

// File: rtl/decode_stage_hs.sv
// Decode stage with register file, immediate generation, operand forwarding, branch compare,
// jump-target computation and a valid/ready ID/EX pipeline register.
// Optional skid entry on the ID/EX boundary is enabled by defining DECODE_SKID_EN.
module decode_stage_hs #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CTRL_W  = 12,
  localparam int unsigned FS_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_i,
  output logic                    id_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic                    nop_i,
  input  logic                    flush_i,
  input  logic [2:0]              imm_typ_i,
  input  logic                    jalr_i,
  input  logic                    alu_src1_i,
  input  logic [1:0]              alu_src2_i,
  input  logic                    sgn_unsgn_i,
  input  logic [FS_W-1:0]         fwd_sel1_i,
  input  logic [FS_W-1:0]         fwd_sel2_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  input  logic                    rf_we_i,
  input  logic [4:0]              rf_waddr_i,
  input  logic [XLEN-1:0]         rf_wdata_i,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [6:0]              opcode_o,
  output logic [2:0]              func3_o,
  output logic [6:0]              func7_o,
  output logic                    eq_o,
  output logic                    lt_o,
  output logic                    ge_o,
  output logic [XLEN-1:0]         jump_addr_o,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [CTRL_W-1:0]       ex_ctrl_o,
  output logic [XLEN-1:0]         ex_pc_o,
  output logic [XLEN-1:0]         ex_a_o,
  output logic [XLEN-1:0]         ex_b_o,
  output logic [XLEN-1:0]         ex_sdata_o,
  output logic [4:0]              ex_rd_o
);

  localparam int unsigned PW = CTRL_W + 4 * XLEN + 5;

  assign opcode_o = inst_i[6:0];
  assign func3_o  = inst_i[14:12];
  assign rs1_o    = inst_i[19:15];
  assign rs2_o    = inst_i[24:20];
  assign func7_o  = inst_i[31:25];

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];
  logic [XLEN-1:0] rf_rd1, rf_rd2, op1, op2, imm, opa, opb, jump_sum;
  logic [31:0]     imm32;
  logic [CTRL_W-1:0] ctrl_eff;
  logic [PW-1:0]   in_pl, main_q, main_d;
  logic            ex_valid_q, ex_valid_d, accept, main_free;

  // Register-file write port; x0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (rf_we_i && rf_waddr_i != 5'd0) rf_d[rf_waddr_i] = rf_wdata_i;
  end

  // Register-file storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Combinational reads with write-through bypass from WB.
  always_comb begin
    rf_rd1 = '0;
    rf_rd2 = '0;
    if (rs1_o != 5'd0) rf_rd1 = (rf_we_i && rf_waddr_i == rs1_o) ? rf_wdata_i : rf_q[rs1_o];
    if (rs2_o != 5'd0) rf_rd2 = (rf_we_i && rf_waddr_i == rs2_o) ? rf_wdata_i : rf_q[rs2_o];
  end

  // Forwarding mux: select 0 is the register file, k picks bus k-1, out-of-range gives 0.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (fwd_sel1_i == '0) op1 = rf_rd1;
    if (fwd_sel2_i == '0) op2 = rf_rd2;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (32'(fwd_sel1_i) == k + 1) op1 = fwd_data_i[k*XLEN +: XLEN];
      if (32'(fwd_sel2_i) == k + 1) op2 = fwd_data_i[k*XLEN +: XLEN];
    end
  end

  // Immediate generation, built at 32 bits then sign-extended to XLEN.
  always_comb begin
    unique case (imm_typ_i)
      3'd0:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      3'd1:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      3'd2:    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      3'd3:    imm32 = {inst_i[31:12], 12'b0};
      3'd4:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                        1'b0};
      3'd5:    imm32 = {27'b0, inst_i[24:20]};
      default: imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
  end

  // ALU operand selection, branch compare and jump target.
  always_comb begin
    opa = alu_src1_i ? pc_i : op1;
    unique case (alu_src2_i)
      2'd0:    opb = op2;
      2'd1:    opb = imm;
      2'd2:    opb = XLEN'(4);
      default: opb = '0;
    endcase
    eq_o        = (op1 == op2);
    lt_o        = sgn_unsgn_i ? (op1 < op2) : ($signed(op1) < $signed(op2));
    ge_o        = ~lt_o;
    jump_sum    = (jalr_i ? op1 : pc_i) + imm;
    jump_addr_o = {jump_sum[XLEN-1:1], jump_sum[0] & ~jalr_i};
  end

  assign ctrl_eff  = nop_i ? '0 : ctrl_i;
  assign in_pl     = {ctrl_eff, pc_i, opa, opb, op2, inst_i[11:7]};
  assign accept    = id_valid_i & id_ready_o;
  assign main_free = ~ex_valid_q | ex_ready_i;

`ifdef DECODE_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          skid_valid_q, skid_valid_d;

  // Ready comes from a flop so EX backpressure never reaches IF combinationally.
  assign id_ready_o = ~skid_valid_q;

  // ID/EX and skid next state; the skid drains first to keep acceptance order.
  always_comb begin
    main_d       = main_q;
    ex_valid_d   = ex_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        ex_valid_d   = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        ex_valid_d = accept;
        if (accept) main_d = in_pl;
      end
    end else if (accept) begin
      skid_d       = in_pl;
      skid_valid_d = 1'b1;
    end
    if (flush_i) begin
      ex_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign id_ready_o = main_free;

  // ID/EX next state without a skid entry.
  always_comb begin
    main_d     = main_q;
    ex_valid_d = ex_valid_q;
    if (main_free) begin
      ex_valid_d = accept;
      if (accept) main_d = in_pl;
    end
    if (flush_i) ex_valid_d = 1'b0;
  end
`endif

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign {ex_ctrl_o, ex_pc_o, ex_a_o, ex_b_o, ex_sdata_o, ex_rd_o} = main_q;

endmodule
